// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads (highest priority), host writes
// (valid/ready) and a fill-colour clear engine share one synchronous-read RAM port.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 19200,
  parameter int STARVE_MAX = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_starved,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a host write transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready never looks at wr_valid, and wr_valid/wr_addr/wr_data hold until then.

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] clr_color;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;
  logic              clr_issue;
  logic              wr_fire;
  logic [1:0]        disp_pipe;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_next;
  logic              op_valid;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;

  assign clr_last   = (clr_addr == ADDR_W'(DEPTH - 1));
  assign wr_fire    = wr_valid && wr_ready;
  assign disp_valid = disp_pipe[1];
  assign disp_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_start) state_next = CLEAR;
      CLEAR:   if (clr_issue && clr_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_busy  = (state == CLEAR);
    clr_issue = (state == CLEAR) && !disp_req;
    wr_ready  = !reset && !disp_req && (state == IDLE);
  end

  // One RAM operation per cycle: display, then host write, then clear.
  always_comb begin
    op_valid = 1'b0;
    op_we    = 1'b0;
    op_addr  = mem_addr;
    op_wdata = mem_wdata;
    if (disp_req) begin
      op_valid = 1'b1;
      op_addr  = disp_addr;
    end else if (wr_fire) begin
      op_valid = 1'b1;
      op_we    = 1'b1;
      op_addr  = wr_addr;
      op_wdata = wr_data;
    end else if (clr_issue) begin
      op_valid = 1'b1;
      op_we    = 1'b1;
      op_addr  = clr_addr;
      op_wdata = clr_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (op_valid) begin
      mem_addr  <= op_addr;
      mem_we    <= op_we;
      mem_wdata <= op_wdata;
    end else begin
      mem_we <= 1'b0;
    end
  end

  // Colour is only captured from IDLE, so a restart request mid-clear is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_color <= '0;
      clr_addr  <= '0;
      clr_done  <= 1'b0;
    end else begin
      clr_done <= clr_issue && clr_last;
      if (state == IDLE && clr_start) begin
        clr_color <= clr_data;
        clr_addr  <= '0;
      end else if (clr_issue && !clr_last) begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) disp_pipe <= 2'b00;
    else       disp_pipe <= {disp_pipe[0], disp_req};
  end

  always_comb begin
    starve_next = '0;
    if (wr_valid && !wr_ready) begin
      if (starve_cnt == CNT_W'(STARVE_MAX)) starve_next = starve_cnt;
      else                                  starve_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      wr_starved <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      if (starve_next == CNT_W'(STARVE_MAX)) wr_starved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous-read RAM;
// DEPTH=16 and STARVE_MAX=8 keep the clear and starvation scenarios short.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_rdata;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              clr_start = 1'b0;
  logic [DATA_W-1:0] clr_data = '0;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_starved;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(16), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_starved(wr_starved),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (pre_we)      ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              exp_ready;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic dr, logic [7:0] da, logic wv, logic [7:0] wa, logic [7:0] wd,
                              logic er, logic ew, logic [7:0] ea, logic [7:0] ed);
    vec_t v;
    v.disp_req = dr; v.disp_addr = da; v.wr_valid = wv; v.wr_addr = wa; v.wr_data = wd;
    v.exp_ready = er; v.exp_we = ew; v.exp_addr = ea; v.exp_wdata = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  function automatic logic disp_at(input int k);
    return (k == 3) || (k == 4) || (k == 8) || (k == 9);
  endfunction

  initial begin
    logic [7:0] rd_vals [4];
    logic       exp_v;
    logic       exp_we;
    int         we_seen;

    vecs[0] = mk(1, 8'h20, 1, 8'h10, 8'h55, 0, 0, 8'h20, 8'h00);
    vecs[1] = mk(1, 8'h21, 1, 8'h10, 8'h55, 0, 0, 8'h21, 8'h00);
    vecs[2] = mk(1, 8'h22, 1, 8'h10, 8'h55, 0, 0, 8'h22, 8'h00);
    vecs[3] = mk(0, 8'h00, 1, 8'h10, 8'h55, 1, 1, 8'h10, 8'h55);
    vecs[4] = mk(0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h55);
    vecs[5] = mk(0, 8'h00, 1, 8'h11, 8'h66, 1, 1, 8'h11, 8'h66);
    vecs[6] = mk(1, 8'h30, 1, 8'h12, 8'h77, 0, 0, 8'h30, 8'h66);
    vecs[7] = mk(0, 8'h00, 1, 8'h12, 8'h77, 1, 1, 8'h12, 8'h77);
    vecs[8] = mk(0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 8'h12, 8'h77);
    rd_vals = '{8'hA3, 8'hB4, 8'hC5, 8'hD6};

    // Reset values
    tick();
    check("ready_in_reset", wr_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_wr_starved", wr_starved, 0);
    check("rst_wr_ready", wr_ready, 1);
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_we) we_seen++;
    end
    check("idle_mem_we_count", we_seen, 0);

    // Display read: single, then back-to-back
    for (int i = 0; i < 4; i++) preload(8'(5 + i), rd_vals[i]);
    disp_req = 1'b1; disp_addr = 8'h05;
    tick();
    disp_req = 1'b0;
    #1;
    check("rd_n1_valid", disp_valid, 0);
    check("rd_n1_mem_addr", mem_addr, 8'h05);
    check("rd_n1_mem_we", mem_we, 0);
    tick();
    check("rd_n2_valid", disp_valid, 1);
    check("rd_n2_rdata", disp_rdata, 8'hA3);
    tick();
    check("rd_n3_valid", disp_valid, 0);
    for (int i = 0; i < 7; i++) begin
      disp_req = (i < 4); disp_addr = 8'(5 + i);
      #1;
      exp_v = (i >= 2) && (i <= 5);
      check("b2b_valid", disp_valid, exp_v);
      if (exp_v) check("b2b_rdata", disp_rdata, rd_vals[i-2]);
      tick();
    end

    // Host write vs display, table-driven
    for (int i = 0; i < 9; i++) begin
      disp_req = vecs[i].disp_req; disp_addr = vecs[i].disp_addr;
      wr_valid = vecs[i].wr_valid; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      #1;
      check("tbl_wr_ready", wr_ready, vecs[i].exp_ready);
      tick();
      check("tbl_mem_we", mem_we, vecs[i].exp_we);
      check("tbl_mem_addr", mem_addr, vecs[i].exp_addr);
      check("tbl_mem_wdata", mem_wdata, vecs[i].exp_wdata);
    end
    disp_req = 1'b0; wr_valid = 1'b0;

    // Clear without display traffic; restart attempt at k=5 is ignored
    clr_start = 1'b1; clr_data = 8'h1C;
    tick();
    for (int k = 1; k <= 20; k++) begin
      clr_start = (k == 5); clr_data = (k == 5) ? 8'hE3 : 8'h00;
      #1;
      check("clr1_busy", clr_busy, k <= 16);
      check("clr1_done", clr_done, k == 17);
      check("clr1_ready", wr_ready, k > 16);
      check("clr1_we", mem_we, (k >= 2) && (k <= 17));
      if ((k >= 2) && (k <= 17)) begin
        check("clr1_addr", mem_addr, k - 2);
        check("clr1_wdata", mem_wdata, 8'h1C);
      end
      tick();
    end
    clr_start = 1'b0;
    for (int a = 0; a < 16; a++) check("clr1_ram", ram[a], 8'h1C);
    check("clr1_no_wrap", ram[16], 8'h55);
    check("clr1_ram17", ram[17], 8'h66);

    // Clear with 4 display cycles and a host write accepted alongside clr_start
    clr_start = 1'b1; clr_data = 8'h42;
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 8'h99;
    #1;
    check("clr2_start_ready", wr_ready, 1);
    tick();
    clr_start = 1'b0; wr_valid = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      disp_req = disp_at(k); disp_addr = 8'h05;
      #1;
      exp_we = (k == 1) || ((k >= 2) && (k <= 21) && !disp_at(k - 1));
      check("clr2_busy", clr_busy, k <= 20);
      check("clr2_done", clr_done, k == 21);
      check("clr2_ready", wr_ready, k > 20);
      check("clr2_we", mem_we, exp_we);
      if (k == 1) begin
        check("clr2_host_addr", mem_addr, 8'h20);
        check("clr2_host_wdata", mem_wdata, 8'h99);
      end
      tick();
    end
    disp_req = 1'b0;
    for (int a = 0; a < 16; a++) check("clr2_ram", ram[a], 8'h42);
    check("clr2_host_ram", ram[8'h20], 8'h99);

    // Reset mid-clear: reset sampled in the cycle of the 8th write
    clr_start = 1'b1; clr_data = 8'h07;
    tick();
    clr_start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    #1;
    check("rmc_we_8th", mem_we, 1);
    check("rmc_addr_8th", mem_addr, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we_seen = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("rmc_busy", clr_busy, 0);
      check("rmc_done", clr_done, 0);
      if (mem_we) we_seen++;
      tick();
    end
    check("rmc_we_count", we_seen, 0);
    for (int a = 0; a < 8; a++) check("rmc_ram_lo", ram[a], 8'h07);
    for (int a = 8; a < 16; a++) check("rmc_ram_hi", ram[a], 8'h42);

    // Starvation: interrupted blocking never trips the flag
    wr_addr = 8'h40; wr_data = 8'h11;
    for (int k = 0; k < 12; k++) begin
      wr_valid = 1'b1; disp_req = (k != 5);
      #1;
      check("starve_partial", wr_starved, 0);
      tick();
    end
    wr_valid = 1'b0; disp_req = 1'b0;
    tick();
    check("starve_partial_end", wr_starved, 0);
    for (int k = 0; k < 10; k++) begin
      wr_valid = 1'b1; disp_req = 1'b1;
      #1;
      check("starve_rise", wr_starved, k >= 8);
      tick();
    end
    disp_req = 1'b0;
    tick();
    wr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("starve_sticky", wr_starved, 1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("starve_reset", wr_starved, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
